// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store initiator on a req/gnt/rvalid bus; define LSU_MISALIGNED_EN to split word-crossing accesses
module load_store_unit #(
  parameter int TIMEOUT_W = 4
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;
  // last counter value before the 2^W-1 cycle limit expires
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
  state_t state, state_nxt;
  logic we_q, rsp_err_q, illegal_in, bad_in, in_wait, in_req, timeout;
  logic [2:0] funct3_q;
  logic [31:0] addr_q, wdata_q, rdata1_q, rsp_rdata_q, hi, lo, shifted, load_val, wdata_rot;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [4:0] sh;
  function automatic logic [7:0] lanes(input logic [1:0] sz, input logic [1:0] off);
    return {4'b0000, sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111} << off;
  endfunction
  assign illegal_in = req_we_i ? (req_funct3_i >= 3'b011)
                               : (req_funct3_i[1:0] == 2'b11 || req_funct3_i[2:1] == 2'b11);
`ifdef LSU_MISALIGNED_EN
  logic [7:0] be8;
  assign be8    = lanes(funct3_q[1:0], addr_q[1:0]);
  assign bad_in = illegal_in;
  assign in_req = state == REQ1 || state == REQ2;
  assign in_wait = state == WAIT1 || state == WAIT2;
  assign hi     = state == WAIT2 ? mem_rdata_i : 32'h0;
`else
  logic [3:0] be_lo;
  assign be_lo  = 4'(lanes(funct3_q[1:0], addr_q[1:0]));
  assign bad_in = illegal_in || lanes(req_funct3_i[1:0], req_addr_i[1:0]) > 8'h0F;
  assign in_req = state == REQ1;
  assign in_wait = state == WAIT1;
  assign hi     = 32'h0;
`endif
  assign timeout   = in_wait && !mem_rvalid_i && cnt_q == CNT_LAST;
  assign sh        = {addr_q[1:0], 3'b000};
  assign lo        = state == WAIT1 ? mem_rdata_i : rdata1_q;
  assign shifted   = 32'({hi, lo} >> sh);
  assign load_val  = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]}
                   : funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]}
                   : shifted;
  assign wdata_rot = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, sh}));
  // state register; reset aborts any transaction in flight
  always_ff @(posedge clk_i or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid_i ? (bad_in ? RESP : REQ1) : IDLE;
      REQ1:    state_nxt = mem_gnt_i ? WAIT1 : REQ1;
`ifdef LSU_MISALIGNED_EN
      WAIT1:   state_nxt = mem_rvalid_i ? (|be8[7:4] ? REQ2 : RESP) : timeout ? RESP : WAIT1;
      REQ2:    state_nxt = mem_gnt_i ? WAIT2 : REQ2;
      WAIT2:   state_nxt = (mem_rvalid_i || timeout) ? RESP : WAIT2;
`else
      WAIT1:   state_nxt = (mem_rvalid_i || timeout) ? RESP : WAIT1;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // bus and response outputs decoded from state and latched request
  always_comb begin
    req_ready_o = state == IDLE;
    rsp_valid_o = state == RESP;
    rsp_rdata_o = rsp_rdata_q;
    rsp_err_o   = rsp_err_q;
    mem_req_o   = in_req;
    mem_we_o    = in_req && we_q;
    mem_wdata_o = in_req ? wdata_rot : '0;
`ifdef LSU_MISALIGNED_EN
    mem_be_o    = state == REQ1 ? be8[3:0] : state == REQ2 ? be8[7:4] : '0;
    mem_addr_o  = state == REQ1 ? {addr_q[31:2], 2'b00}
                : state == REQ2 ? {addr_q[31:2] + 30'd1, 2'b00} : '0;
`else
    mem_be_o    = state == REQ1 ? be_lo : '0;
    mem_addr_o  = state == REQ1 ? {addr_q[31:2], 2'b00} : '0;
`endif
  end
  // request latch, read capture, wait counter and response registers
  always_ff @(posedge clk_i or negedge reset_n)
    if (!reset_n) begin
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata1_q    <= '0;
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      if (state == WAIT1 && mem_rvalid_i) rdata1_q <= mem_rdata_i;
      cnt_q <= in_wait ? cnt_q + 1'b1 : '0;
      if (state != RESP && state_nxt == RESP) begin
        rsp_err_q   <= state == IDLE || timeout;
        rsp_rdata_q <= (state == IDLE || timeout || we_q) ? '0 : load_val;
      end
    end
endmodule
